// File: rtl/pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reconfig_ctrl
//
// Runtime controller for a Gowin rPLL with dynamic dividers. It picks one of
// NUM_MODES fdiv/idiv presets, sequences the PLL reset, supervises lock with a
// timeout and a bounded number of retries, and publishes a debounced locked
// flag to the downstream video logic.
//
// Ports:
//   i_refclk         controller clock (free-running PLL reference)
//   i_reset          synchronous, active-high reset
//   i_mode_sel       requested preset index
//   i_mode_req       request strobe, evaluated every cycle
//   o_mode_ack       one-cycle pulse: request accepted
//   o_mode_nack      one-cycle pulse: request rejected (index out of range)
//   o_busy           high while a PLL bring-up sequence is in progress
//   i_pll_lock       raw, asynchronous lock flag from the PLL
//   o_fdiv, o_idiv   divider values driven to the PLL
//   o_pll_reset      reset driven to the PLL
//   o_locked         PLL output is stable and usable
//   o_error          retries exhausted, PLL parked in reset
//   o_cur_mode       preset currently applied
//   o_lock_loss_cnt  saturating count of lock-loss events
//
// Optional feature macro: PLL_LOCK_LOSS_COUNT_EN
//   defined   -> o_lock_loss_cnt counts LOCKED->RST_PLL transitions caused by
//                lock loss, saturating at 16'hFFFF, cleared only by reset
//   undefined -> o_lock_loss_cnt is tied to zero and no counter is built
// ---------------------------------------------------------------------------
module pll_reconfig_ctrl #(
  parameter int                            NUM_MODES    = 4,
  parameter int                            FDIV_W       = 6,
  parameter int                            IDIV_W       = 6,
  parameter logic [NUM_MODES*FDIV_W-1:0]   FDIV_TABLE   = {6'd29, 6'd37, 6'd44, 6'd50},
  parameter logic [NUM_MODES*IDIV_W-1:0]   IDIV_TABLE   = {6'd4, 6'd5, 6'd6, 6'd7},
  parameter int                            DEFAULT_MODE = 0,
  parameter int                            RESET_CYCLES = 16,
  parameter int                            LOCK_TIMEOUT = 65536,
  parameter int                            LOCK_STABLE  = 1024,
  parameter int                            MAX_RETRIES  = 3
) (
  input  logic                         i_refclk,
  input  logic                         i_reset,
  input  logic [$clog2(NUM_MODES)-1:0] i_mode_sel,
  input  logic                         i_mode_req,
  output logic                         o_mode_ack,
  output logic                         o_mode_nack,
  output logic                         o_busy,
  input  logic                         i_pll_lock,
  output logic [FDIV_W-1:0]            o_fdiv,
  output logic [IDIV_W-1:0]            o_idiv,
  output logic                         o_pll_reset,
  output logic                         o_locked,
  output logic                         o_error,
  output logic [$clog2(NUM_MODES)-1:0] o_cur_mode,
  output logic [15:0]                  o_lock_loss_cnt
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int TO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int STB_W  = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
  localparam int RET_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  // The lock sample taken in WAIT_LOCK counts as the first of the LOCK_STABLE
  // consecutive samples, so STABLE itself needs one sample fewer.
  localparam logic [STB_W-1:0]  STB_DONE  = STB_W'((LOCK_STABLE > 1) ? (LOCK_STABLE - 2) : 0);
  localparam logic [RET_W-1:0]  RET_MAX   = RET_W'(MAX_RETRIES);
  localparam logic [MODE_W:0]   MODES_LIM = (MODE_W + 1)'(NUM_MODES);
  localparam logic [MODE_W-1:0] DEF_MODE  = MODE_W'(DEFAULT_MODE);
  localparam logic [FDIV_W-1:0] FDIV_DEF  = FDIV_TABLE[DEFAULT_MODE*FDIV_W +: FDIV_W];
  localparam logic [IDIV_W-1:0] IDIV_DEF  = IDIV_TABLE[DEFAULT_MODE*IDIV_W +: IDIV_W];

  localparam logic [2:0] ST_RST_PLL   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_LOCKED    = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  logic [2:0]        r_state;
  logic [RST_W-1:0]  r_rstCnt;
  logic [TO_W-1:0]   r_toCnt;
  logic [STB_W-1:0]  r_stableCnt;
  logic [RET_W-1:0]  r_retries;
  logic [MODE_W-1:0] r_curMode;
  logic [FDIV_W-1:0] r_fdiv;
  logic [IDIV_W-1:0] r_idiv;
  logic              r_modeAck;
  logic              r_modeNack;
  logic              r_sync1;
  logic              r_sync2;

  logic              w_lockS;
  logic              w_selValid;
  logic [MODE_W-1:0] w_selIdx;
  logic              w_idle;
  logic              w_accept;
  logic              w_reject;
  logic              w_lockLoss;
  logic [RET_W-1:0]  w_retNext;
  logic [FDIV_W-1:0] w_fdivTab [NUM_MODES];
  logic [IDIV_W-1:0] w_idivTab [NUM_MODES];

  // Unpack the preset tables once so the request path is a plain array lookup.
  genvar g;
  for (g = 0; g < NUM_MODES; g++) begin : g_tab
    assign w_fdivTab[g] = FDIV_TABLE[g*FDIV_W +: FDIV_W];
    assign w_idivTab[g] = IDIV_TABLE[g*IDIV_W +: IDIV_W];
  end

  // Two-flop synchroniser for the asynchronous PLL lock flag; nothing else in
  // the controller ever looks at i_pll_lock directly.
  always_ff @(posedge i_refclk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lockS    = r_sync2;
  assign w_selValid = ({1'b0, i_mode_sel} < MODES_LIM);
  // Out-of-range indices are steered to entry 0 so the table is never read
  // past its end, even on a cycle whose request will be rejected.
  assign w_selIdx   = w_selValid ? i_mode_sel : '0;
  assign w_idle     = (r_state == ST_LOCKED) || (r_state == ST_FAIL);
  assign w_accept   = w_idle && i_mode_req && w_selValid;
  assign w_reject   = w_idle && i_mode_req && !w_selValid;
  assign w_lockLoss = (r_state == ST_LOCKED) && !w_lockS;
  assign w_retNext  = r_retries + 1'b1;

  // Main sequencer. The state case handles the PLL bring-up; an accepted
  // request is evaluated afterwards so it overrides whatever the case chose,
  // which lets a request win over a simultaneous lock loss. Dividers are only
  // reloaded on an accepted request, i.e. on entry to RST_PLL, so they never
  // move while the PLL is running.
  always_ff @(posedge i_refclk) begin
    if (i_reset) begin
      r_state     <= ST_RST_PLL;
      r_rstCnt    <= '0;
      r_toCnt     <= '0;
      r_stableCnt <= '0;
      r_retries   <= '0;
      r_curMode   <= DEF_MODE;
      r_fdiv      <= FDIV_DEF;
      r_idiv      <= IDIV_DEF;
      r_modeAck   <= 1'b0;
      r_modeNack  <= 1'b0;
    end else begin
      r_modeAck  <= 1'b0;
      r_modeNack <= 1'b0;

      case (r_state)
        ST_RST_PLL: begin
          if (r_rstCnt == RST_LAST) begin
            r_state <= ST_WAIT_LOCK;
            r_toCnt <= '0;
          end else begin
            r_rstCnt <= r_rstCnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (w_lockS) begin
            r_state     <= ST_STABLE;
            r_stableCnt <= '0;
          end else if (r_toCnt == TO_LAST) begin
            r_retries <= w_retNext;
            r_rstCnt  <= '0;
            r_state   <= (w_retNext == RET_MAX) ? ST_FAIL : ST_RST_PLL;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end

        // The timeout counter is deliberately left alone here so that a lock
        // glitch resumes the same timeout window instead of restarting it.
        ST_STABLE: begin
          if (!w_lockS) begin
            r_state <= ST_WAIT_LOCK;
          end else if (r_stableCnt >= STB_DONE) begin
            r_state   <= ST_LOCKED;
            r_retries <= '0;
          end else begin
            r_stableCnt <= r_stableCnt + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (w_lockLoss) begin
            r_state   <= ST_RST_PLL;
            r_rstCnt  <= '0;
            r_retries <= '0;
          end
        end

        ST_FAIL: begin
          r_state <= ST_FAIL;
        end

        default: begin
          r_state  <= ST_RST_PLL;
          r_rstCnt <= '0;
        end
      endcase

      if (w_accept) begin
        r_state   <= ST_RST_PLL;
        r_rstCnt  <= '0;
        r_retries <= '0;
        r_curMode <= i_mode_sel;
        r_fdiv    <= w_fdivTab[w_selIdx];
        r_idiv    <= w_idivTab[w_selIdx];
        r_modeAck <= 1'b1;
      end else if (w_reject) begin
        r_modeNack <= 1'b1;
      end
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [15:0] r_lossCnt;

  // Counts every lock loss seen in LOCKED, including one that coincides with
  // an accepted request; saturates rather than wrapping.
  always_ff @(posedge i_refclk) begin
    if (i_reset) begin
      r_lossCnt <= '0;
    end else if (w_lockLoss && (r_lossCnt != 16'hFFFF)) begin
      r_lossCnt <= r_lossCnt + 16'd1;
    end
  end

  assign o_lock_loss_cnt = r_lossCnt;
`else
  assign o_lock_loss_cnt = 16'd0;
`endif

  assign o_mode_ack  = r_modeAck;
  assign o_mode_nack = r_modeNack;
  assign o_busy      = (r_state == ST_RST_PLL) || (r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE);
  assign o_pll_reset = (r_state == ST_RST_PLL) || (r_state == ST_FAIL);
  assign o_locked    = (r_state == ST_LOCKED);
  assign o_error     = (r_state == ST_FAIL);
  assign o_cur_mode  = r_curMode;
  assign o_fdiv      = r_fdiv;
  assign o_idiv      = r_idiv;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_ctrl
//
// Self-checking bench for pll_reconfig_ctrl. A table of {inputs, cycles,
// expected outputs} records walks the controller through bring-up, a mode
// change, busy-time and out-of-range requests and repeated lock loss; hand
// sequences then cover retry exhaustion, a lock glitch and a mid-sequence
// reset. Five presets are used so a 3-bit mode_sel can carry out-of-range
// values. Honours PLL_LOCK_LOSS_COUNT_EN for the lock-loss count expectations.
// ---------------------------------------------------------------------------
module tb_pll_reconfig_ctrl;

  localparam int NUM_MODES = 5;
  localparam int FDIV_W    = 6;
  localparam int IDIV_W    = 6;
  localparam int MODE_W    = 3;
  // Entries 0..4: fdiv 50,41,33,27,19  idiv 7,5,3,9,2
  localparam logic [NUM_MODES*FDIV_W-1:0] FDIV_TAB = {6'd19, 6'd27, 6'd33, 6'd41, 6'd50};
  localparam logic [NUM_MODES*IDIV_W-1:0] IDIV_TAB = {6'd2, 6'd9, 6'd3, 6'd5, 6'd7};

`ifdef PLL_LOCK_LOSS_COUNT_EN
  localparam int LLC_EN = 1;
`else
  localparam int LLC_EN = 0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [MODE_W-1:0] modeSel;
  logic              modeReq;
  logic              modeAck;
  logic              modeNack;
  logic              busy;
  logic              pllLock;
  logic [FDIV_W-1:0] fdiv;
  logic [IDIV_W-1:0] idiv;
  logic              pllReset;
  logic              locked;
  logic              error;
  logic [MODE_W-1:0] curMode;
  logic [15:0]       lockLossCnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic              rst;
    logic              req;
    logic [MODE_W-1:0] sel;
    logic              lock;
    int                cycles;
    logic              expPllReset;
    logic              expBusy;
    logic              expLocked;
    logic              expError;
    logic              expAck;
    logic              expNack;
    logic [MODE_W-1:0] expMode;
    logic [FDIV_W-1:0] expFdiv;
    logic [IDIV_W-1:0] expIdiv;
    logic [15:0]       expLlc;
  } vec_t;

  vec_t vecs[$];

  pll_reconfig_ctrl #(
    .NUM_MODES   (NUM_MODES),
    .FDIV_W      (FDIV_W),
    .IDIV_W      (IDIV_W),
    .FDIV_TABLE  (FDIV_TAB),
    .IDIV_TABLE  (IDIV_TAB),
    .DEFAULT_MODE(0),
    .RESET_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE (8),
    .MAX_RETRIES (2)
  ) dut (
    .i_refclk       (clock),
    .i_reset        (reset),
    .i_mode_sel     (modeSel),
    .i_mode_req     (modeReq),
    .o_mode_ack     (modeAck),
    .o_mode_nack    (modeNack),
    .o_busy         (busy),
    .i_pll_lock     (pllLock),
    .o_fdiv         (fdiv),
    .o_idiv         (idiv),
    .o_pll_reset    (pllReset),
    .o_locked       (locked),
    .o_error        (error),
    .o_cur_mode     (curMode),
    .o_lock_loss_cnt(lockLossCnt)
  );

  // Free-running reference clock, 10 time units per period.
  always #5 clock = ~clock;

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] llc(input int n);
    return (LLC_EN != 0) ? 16'(n) : 16'd0;
  endfunction

  function automatic vec_t mk(input logic r, input logic q, input logic [MODE_W-1:0] s,
                              input logic l, input int n, input logic pr, input logic bz,
                              input logic lk, input logic er, input logic ak, input logic nk,
                              input logic [MODE_W-1:0] m, input logic [FDIV_W-1:0] f,
                              input logic [IDIV_W-1:0] d, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.sel = s; v.lock = l; v.cycles = n;
    v.expPllReset = pr; v.expBusy = bz; v.expLocked = lk; v.expError = er;
    v.expAck = ak; v.expNack = nk; v.expMode = m; v.expFdiv = f; v.expIdiv = d;
    v.expLlc = c;
    return v;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkSig(input string tag, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset   = v.rst;
    modeReq = v.req;
    modeSel = v.sel;
    pllLock = v.lock;
    tick(v.cycles);
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkSig({tag, ".pll_reset"}, 16'(pllReset),    16'(v.expPllReset));
    checkSig({tag, ".busy"},      16'(busy),        16'(v.expBusy));
    checkSig({tag, ".locked"},    16'(locked),      16'(v.expLocked));
    checkSig({tag, ".error"},     16'(error),       16'(v.expError));
    checkSig({tag, ".ack"},       16'(modeAck),     16'(v.expAck));
    checkSig({tag, ".nack"},      16'(modeNack),    16'(v.expNack));
    checkSig({tag, ".cur_mode"},  16'(curMode),     16'(v.expMode));
    checkSig({tag, ".fdiv"},      16'(fdiv),        16'(v.expFdiv));
    checkSig({tag, ".idiv"},      16'(idiv),        16'(v.expIdiv));
    checkSig({tag, ".llc"},       lockLossCnt,      v.expLlc);
  endtask

  initial begin
    reset   = 1'b1;
    modeReq = 1'b0;
    modeSel = '0;
    pllLock = 1'b0;

    // ---- table: bring-up ----
    vecs.push_back(mk(1,0,0,0, 3, 1,1,0,0,0,0, 0,50,7, 0));
    vecs.push_back(mk(0,0,0,0, 3, 1,1,0,0,0,0, 0,50,7, 0));
    vecs.push_back(mk(0,0,0,0, 1, 0,1,0,0,0,0, 0,50,7, 0));
    vecs.push_back(mk(0,0,0,0, 3, 0,1,0,0,0,0, 0,50,7, 0));
    vecs.push_back(mk(0,0,0,1, 9, 0,1,0,0,0,0, 0,50,7, 0));
    vecs.push_back(mk(0,0,0,1, 1, 0,0,1,0,0,0, 0,50,7, 0));
    // ---- mode change to 2, with a request ignored while busy ----
    vecs.push_back(mk(0,1,2,1, 1, 1,1,0,0,1,0, 2,33,3, 0));
    vecs.push_back(mk(0,1,3,1, 2, 1,1,0,0,0,0, 2,33,3, 0));
    vecs.push_back(mk(0,0,0,1, 1, 1,1,0,0,0,0, 2,33,3, 0));
    vecs.push_back(mk(0,0,0,1, 1, 0,1,0,0,0,0, 2,33,3, 0));
    vecs.push_back(mk(0,0,0,1, 7, 0,1,0,0,0,0, 2,33,3, 0));
    vecs.push_back(mk(0,0,0,1, 1, 0,0,1,0,0,0, 2,33,3, 0));
    // ---- out-of-range requests while LOCKED ----
    vecs.push_back(mk(0,1,5,1, 1, 0,0,1,0,0,1, 2,33,3, 0));
    vecs.push_back(mk(0,0,0,1, 1, 0,0,1,0,0,0, 2,33,3, 0));
    vecs.push_back(mk(0,1,7,1, 1, 0,0,1,0,0,1, 2,33,3, 0));
    vecs.push_back(mk(0,0,0,1, 1, 0,0,1,0,0,0, 2,33,3, 0));
    // ---- three lock losses, each followed by relock ----
    for (int n = 1; n <= 3; n++) begin
      vecs.push_back(mk(0,0,0,0,  2, 0,0,1,0,0,0, 2,33,3, llc(n-1)));
      vecs.push_back(mk(0,0,0,0,  1, 1,1,0,0,0,0, 2,33,3, llc(n)));
      vecs.push_back(mk(0,0,0,1, 11, 0,1,0,0,0,0, 2,33,3, llc(n)));
      vecs.push_back(mk(0,0,0,1,  1, 0,0,1,0,0,0, 2,33,3, llc(n)));
    end
    // ---- request coinciding with lock loss: request wins, loss counted ----
    vecs.push_back(mk(0,0,0,0, 2, 0,0,1,0,0,0, 2,33,3, llc(3)));
    vecs.push_back(mk(0,1,1,0, 1, 1,1,0,0,1,0, 1,41,5, llc(4)));
    vecs.push_back(mk(0,0,0,1, 1, 1,1,0,0,0,0, 1,41,5, llc(4)));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // ---- retry exhaustion ----
    reset = 1'b1; modeReq = 1'b0; pllLock = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);  checkSig("rf_rst_hold", 16'(pllReset), 16'd1);
    tick(1);  checkSig("rf_wait1", 16'(pllReset), 16'd0);
    tick(19); checkSig("rf_wait1_end", 16'(pllReset), 16'd0);
              checkSig("rf_wait1_err", 16'(error), 16'd0);
    tick(1);  checkSig("rf_retry_rst", 16'(pllReset), 16'd1);
              checkSig("rf_retry_busy", 16'(busy), 16'd1);
    tick(3);  checkSig("rf_retry_hold", 16'(pllReset), 16'd1);
    tick(1);  checkSig("rf_wait2", 16'(pllReset), 16'd0);
    tick(19); checkSig("rf_wait2_err", 16'(error), 16'd0);
    tick(1);  checkSig("rf_fail_err", 16'(error), 16'd1);
              checkSig("rf_fail_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkSig($sformatf("rf_fail_rst%0d", i), 16'(pllReset), 16'd1);
      checkSig($sformatf("rf_fail_err%0d", i), 16'(error), 16'd1);
      checkSig($sformatf("rf_fail_lk%0d", i),  16'(locked), 16'd0);
    end
    modeReq = 1'b1; modeSel = 3'd6;
    tick(1);  checkSig("rf_nack", 16'(modeNack), 16'd1);
              checkSig("rf_nack_err", 16'(error), 16'd1);
    modeSel = 3'd1;
    tick(1);  checkSig("rf_ack", 16'(modeAck), 16'd1);
              checkSig("rf_ack_err", 16'(error), 16'd0);
              checkSig("rf_ack_mode", 16'(curMode), 16'd1);
              checkSig("rf_ack_fdiv", 16'(fdiv), 16'd41);
              checkSig("rf_ack_idiv", 16'(idiv), 16'd5);
              checkSig("rf_ack_rst", 16'(pllReset), 16'd1);
    modeReq = 1'b0;
    tick(1);  checkSig("rf_ack_pulse", 16'(modeAck), 16'd0);

    // ---- lock glitch inside STABLE ----
    tick(2);  checkSig("gl_rst", 16'(pllReset), 16'd1);
    tick(1);  checkSig("gl_wait", 16'(pllReset), 16'd0);
    tick(3);
    pllLock = 1'b1;
    tick(5);
    pllLock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkSig($sformatf("gl_rst%0d", i), 16'(pllReset), 16'd0);
      checkSig($sformatf("gl_lk%0d", i),  16'(locked), 16'd0);
    end

    // ---- relock, move to mode 3, then reset during WAIT_LOCK ----
    pllLock = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (locked) break;
      tick(1);
    end
    checkSig("mr_relock", 16'(locked), 16'd1);
    modeReq = 1'b1; modeSel = 3'd3;
    tick(1);  checkSig("mr_ack", 16'(modeAck), 16'd1);
              checkSig("mr_fdiv3", 16'(fdiv), 16'd27);
              checkSig("mr_idiv3", 16'(idiv), 16'd9);
    modeReq = 1'b0; pllLock = 1'b0;
    tick(4);  checkSig("mr_wait", 16'(pllReset), 16'd0);
              checkSig("mr_mode3", 16'(curMode), 16'd3);
    tick(2);
    reset = 1'b1;
    tick(1);  checkSig("mr_mode", 16'(curMode), 16'd0);
              checkSig("mr_fdiv", 16'(fdiv), 16'd50);
              checkSig("mr_idiv", 16'(idiv), 16'd7);
              checkSig("mr_rst", 16'(pllReset), 16'd1);
              checkSig("mr_err", 16'(error), 16'd0);
              checkSig("mr_busy", 16'(busy), 16'd1);
              checkSig("mr_llc", lockLossCnt, 16'd0);
    reset = 1'b0;
    tick(1);  checkSig("mr_after", 16'(pllReset), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
